// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: funct codes, shift-unit control codes, FSM states.
// Latency: none (definitions only).
// Backpressure: none.
package shift_pkg;

    // R-type funct codes handled by the sequencer
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;

    // Control codes understood by the shared shift unit
    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_funct_decode.sv
// Decodes funct into shift-unit op and amount source (shamt field or rs[4:0]).
// Latency: combinational.
// Backpressure: none.
module shift_funct_decode
    import shift_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [4:0] shamt_field,
    input  logic [4:0] rs_amt,
    output logic [1:0] op,
    output logic [4:0] amt,
    output logic       illegal
);

    // Map funct to op/amount; anything that is not a shift is flagged illegal with a zero amount
    always_comb begin
        op      = SH_PASS;
        amt     = 5'd0;
        illegal = 1'b0;
        case (funct)
            F_SLL:   begin op = SH_SLL; amt = shamt_field; end
            F_SRL:   begin op = SH_SRL; amt = shamt_field; end
            F_SRA:   begin op = SH_SRA; amt = shamt_field; end
            F_SLLV:  begin op = SH_SLL; amt = rs_amt;      end
            F_SRLV:  begin op = SH_SRL; amt = rs_amt;      end
            F_SRAV:  begin op = SH_SRA; amt = rs_amt;      end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle MIPS R-type shift controller driving an external combinational shift unit in chunks of at most MAX_STEP.
// Latency: start edge to done = 1 + ceil(amt/MAX_STEP) cycles; 1 cycle for amt=0 or illegal funct.
// Backpressure: start is only sampled in IDLE; requests while busy or in the done cycle are dropped, not queued.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int MAX_STEP = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt_field,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [31:0] result,
    output logic [1:0]  shift_ctrl,
    output logic [4:0]  shift_amt,
    output logic [31:0] shift_data,
    input  logic [31:0] shift_result
);

    localparam logic [4:0] STEP_MAX = 5'(MAX_STEP);

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  remaining_q, remaining_d;
    logic        illegal_q, illegal_d;

    logic [1:0]  dec_op;
    logic [4:0]  dec_amt;
    logic        dec_illegal;
    logic [4:0]  chunk;

    // Only the low five bits of rs carry a shift amount
    logic        unused_rs_hi;
    assign unused_rs_hi = ^rs_val[31:5];

    shift_funct_decode u_decode (
        .funct       (funct),
        .shamt_field (shamt_field),
        .rs_amt      (rs_val[4:0]),
        .op          (dec_op),
        .amt         (dec_amt),
        .illegal     (dec_illegal)
    );

    // Amount applied this cycle: whatever is left, capped at the shifter's per-cycle limit
    always_comb begin
        chunk = (remaining_q < STEP_MAX) ? remaining_q : STEP_MAX;
    end

    // Next-state logic: accept in IDLE, feed the shifter output back in STEP, pulse in DONE
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        result_d    = result_q;
        op_d        = op_q;
        remaining_d = remaining_q;
        illegal_d   = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d      = rt_val;
                    op_d        = dec_op;
                    remaining_d = dec_amt;
                    if (dec_illegal) begin
                        result_d  = rt_val;
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (dec_amt == 5'd0) begin
                        result_d = rt_val;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                data_d      = shift_result;
                remaining_d = remaining_q - chunk;
                if (remaining_q == chunk) begin
                    result_d = shift_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                illegal_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            data_q      <= 32'd0;
            result_q    <= 32'd0;
            op_q        <= SH_PASS;
            remaining_q <= 5'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            result_q    <= result_d;
            op_q        <= op_d;
            remaining_q <= remaining_d;
            illegal_q   <= illegal_d;
        end
    end

    // Shift unit is only commanded in STEP; elsewhere it is told to pass through
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        illegal    = illegal_q;
        result     = result_q;
        shift_data = data_q;
        shift_ctrl = (state_q == ST_STEP) ? op_q  : SH_PASS;
        shift_amt  = (state_q == ST_STEP) ? chunk : 5'd0;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multicycle controller that executes MIPS R-type shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV) on the shared combinational shift unit.
- Decodes funct and selects the shift amount from either the shamt field or rs[4:0]. Drives the shift unit's control, amount and data inputs, and feeds its output back until the full amount is applied.
- Step size is bounded by MAX_STEP, so a narrowed or cheaper shifter variant still produces the correct result in more cycles.
- Sits between the main control FSM (start/done handshake) and the shift unit; the result goes to the rd writeback mux.

Parameters:
- MAX_STEP, 31, largest amount applied per cycle; legal range 1..31. 31 gives single-step operation.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- funct  in  6  instruction funct field.
- shamt_field  in  5  instruction shamt field.
- rs_val  in  32  rs register value (variable amount source).
- rt_val  in  32  rt register value (operand).
- busy  out  1  high in STEP and DONE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  high with done when funct is not a shift.
- result  out  32  shifted value; valid from done, held until the next accepted start.
- shift_ctrl  out  2  to shift unit: 00 SLL, 01 SRL, 10 SRA, 11 pass.
- shift_amt  out  5  to shift unit.
- shift_data  out  32  to shift unit.
- shift_result  in  32  from shift unit.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; illegal=0; result=0; data_reg=0; remaining=0; shift_ctrl=11; shift_amt=0. An operation in flight is abandoned with no done pulse.
- Decode: 000000 SLL/shamt_field; 000010 SRL/shamt_field; 000011 SRA/shamt_field; 000100 SLLV/rs_val[4:0]; 000110 SRLV/rs_val[4:0]; 000111 SRAV/rs_val[4:0]. All other funct values are illegal.
- IDLE, start=1, at the sampling edge:
  - Latch data_reg=rt_val, op code and remaining=amt.
  - If illegal: result=rt_val, illegal=1, go DONE.
  - Else if amt=0: result=rt_val, go DONE.
  - Else go STEP.
- IDLE, start=0: stay in IDLE.
- STEP, combinational outputs: shift_ctrl=op; shift_amt=chunk=min(remaining, MAX_STEP); shift_data=data_reg.
- STEP, each edge: data_reg=shift_result; remaining=remaining-chunk. If remaining-chunk=0: result=shift_result, go DONE. Else stay in STEP.
- Multi-step SRA stays arithmetic because each step sign-extends from the current data_reg.
- DONE: done=1 for exactly one cycle; illegal is valid that cycle; next state IDLE. illegal clears on leaving DONE.
- Outside STEP: shift_ctrl=11, shift_amt=0, shift_data=data_reg.
- Latency from the start edge to the cycle where done is high: 1 + ceil(amt/MAX_STEP) cycles; 1 cycle when amt=0 or illegal.
- start while busy is ignored, with no queuing.
- start in the cycle DONE is active is also ignored, because state is not IDLE. The earliest re-issue is the cycle after done.
- Amount width is 5 bits; rs_val[31:5] is ignored. No overflow is possible because remaining ≤ 31.

Decomposition:
- Shared package shift_pkg:
  - funct localparams (F_SLL=000000, F_SRL=000010, F_SRA=000011, F_SLLV=000100, F_SRLV=000110, F_SRAV=000111).
  - shift_ctrl codes (SH_SLL, SH_SRL, SH_SRA, SH_PASS).
  - FSM state encoding (ST_IDLE, ST_STEP, ST_DONE).
- One natural sub-module, shift_funct_decode (combinational): funct, shamt_field and rs_val[4:0] in; op, amt and illegal out.
- The shift unit itself is instantiated outside this block, at datapath level.

Test Plan:
- MAX_STEP=31: start, funct=000000, shamt_field=4, rt=0x0000_0001 -> done 2 cycles after the start edge; result=0x0000_0010; shift_amt=4 during STEP; illegal=0.
- MAX_STEP=8: start, funct=000111 (SRAV), rs=0xFFFF_FFF4 (amt 20), rt=0x8000_0000 -> STEP chunks 8, 8, 4; done 4 cycles after start; result=0xFFFF_F800.
- MAX_STEP=31: funct=000010, shamt_field=0, rt=0xDEAD_BEEF -> done 1 cycle after start; result=0xDEAD_BEEF; shift_ctrl stays 11.
- funct=100000 (ADD), rt=0x1234_5678 -> done 1 cycle after start; illegal=1; result=0x1234_5678; next cycle illegal=0.
- MAX_STEP=4: SRLV amt 31 in progress; assert start again during STEP (ignored); assert reset in the 3rd STEP cycle -> outputs return immediately to reset values; no done pulse; a new start afterwards completes normally.
- Back-to-back: start asserted in the DONE cycle -> ignored; re-asserted the next cycle -> accepted.
